// File: rtl/athos_op_responder.sv
// athos_op_responder
// Accelerator-side responder for the ATHOS CU command interface. Takes one
// op per handshake, pulses the matching engine start, waits for that engine's
// done (or aborts on timeout), then holds a status/cycle-count response until
// the CU consumes it.
module athos_op_responder #(
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             op_valid_i,
    input  logic [5:0]       op_i,
    output logic             op_ready_o,
    output logic [3:0]       eng_start_o,
    output logic [3:0]       eng_abort_o,
    input  logic [3:0]       eng_done_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [5:0]       resp_op_o,
    output logic [1:0]       resp_status_o,
    output logic [CNT_W-1:0] cycles_o,
    output logic             busy_o
);

    // athos_ip_op codes served by this responder
    localparam logic [5:0] OP_NULL   = 6'h00;
    localparam logic [5:0] OP_KECCAK = 6'h01;
    localparam logic [5:0] OP_NTT    = 6'h02;
    localparam logic [5:0] OP_INTT   = 6'h03;
    localparam logic [5:0] OP_TRNG   = 6'h04;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ILLEGAL = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    // Timeout compared against counter+1, which is one bit wider than the counter
    localparam logic [CNT_W:0] TIMEOUT_VAL = (CNT_W+1)'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

    // Engine one-hot for an op code; zero for NULL and illegal codes
    function automatic logic [3:0] op_onehot(input logic [5:0] op);
        logic [3:0] sel;
        case (op)
            OP_KECCAK: sel = 4'b0001;
            OP_NTT:    sel = 4'b0010;
            OP_INTT:   sel = 4'b0100;
            OP_TRNG:   sel = 4'b1000;
            default:   sel = 4'b0000;
        endcase
        return sel;
    endfunction

    state_t           r_state;
    state_t           w_next_state;
    logic [5:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_status;
    logic [CNT_W-1:0] r_cycles;

    logic [3:0]       w_eng_sel;
    logic [3:0]       w_in_sel;
    logic             w_accept;
    logic             w_done;
    logic             w_timeout;
    logic [CNT_W:0]   w_cnt_inc;
    logic [CNT_W-1:0] w_cnt_sat;
    logic [3:0]       w_start;
    logic [3:0]       w_abort;
    logic             w_load_resp;
    logic [1:0]       w_resp_status;
    logic [CNT_W-1:0] w_resp_cycles;

    assign w_eng_sel = op_onehot(r_op);
    assign w_in_sel  = op_onehot(op_i);
    assign w_accept  = op_valid_i && (r_state == S_IDLE);
    assign w_done    = |(eng_done_i & w_eng_sel);
    assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign w_cnt_sat = w_cnt_inc[CNT_W] ? {CNT_W{1'b1}} : w_cnt_inc[CNT_W-1:0];
    assign w_timeout = (w_cnt_inc == TIMEOUT_VAL);

    // Next-state, engine pulses and response capture values
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        w_next_state  = r_state;
        w_start       = 4'b0000;
        w_abort       = 4'b0000;
        w_load_resp   = 1'b0;
        w_resp_status = ST_OK;
        w_resp_cycles = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_in_sel != 4'b0000) begin
                        w_next_state = S_START;
                    end else begin
                        w_next_state  = S_RESP;
                        w_load_resp   = 1'b1;
                        w_resp_status = (op_i == OP_NULL) ? ST_OK : ST_ILLEGAL;
                    end
                end
            end
            S_START: begin
                w_start      = w_eng_sel;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                // Done takes priority over a timeout landing in the same cycle
                if (w_done) begin
                    w_next_state  = S_RESP;
                    w_load_resp   = 1'b1;
                    w_resp_status = ST_OK;
                    w_resp_cycles = w_cnt_sat;
                end else if (w_timeout) begin
                    w_abort       = w_eng_sel;
                    w_next_state  = S_RESP;
                    w_load_resp   = 1'b1;
                    w_resp_status = ST_TIMEOUT;
                    w_resp_cycles = w_cnt_sat;
                end
            end
            S_RESP: begin
                if (resp_ready_i) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State, latched op, cycle counter and held response fields
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments; reset is synchronous and active-low.
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_cnt    <= '0;
            r_status <= ST_OK;
            r_cycles <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_op <= op_i;
            end
            if (r_state == S_START) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= w_cnt_sat;
            end
            if (w_load_resp) begin
                r_status <= w_resp_status;
                r_cycles <= w_resp_cycles;
            end
        end
    end

    // Outputs are forced low while reset is held so nothing leaks out mid-reset
    assign op_ready_o    = rst_ni && (r_state == S_IDLE);
    assign busy_o        = rst_ni && (r_state != S_IDLE);
    assign resp_valid_o  = rst_ni && (r_state == S_RESP);
    assign eng_start_o   = rst_ni ? w_start : 4'b0000;
    assign eng_abort_o   = rst_ni ? w_abort : 4'b0000;
    assign resp_op_o     = resp_valid_o ? r_op : 6'h00;
    assign resp_status_o = resp_valid_o ? r_status : 2'b00;
    assign cycles_o      = resp_valid_o ? r_cycles : '0;

endmodule

// File: tb/tb_athos_op_responder.sv
// tb_athos_op_responder
// Directed bench: instance A uses the default timeout, instance B uses an
// 8-cycle timeout. Inputs change on the falling edge and outputs are sampled
// 1 ns later, away from the rising edge.
module tb_athos_op_responder;

    logic clk;
    logic rst_n;

    logic        a_op_valid, a_op_ready, a_resp_valid, a_resp_ready, a_busy;
    logic [5:0]  a_op, a_resp_op;
    logic [3:0]  a_start, a_abort, a_done;
    logic [1:0]  a_status;
    logic [15:0] a_cycles;

    logic        b_op_valid, b_op_ready, b_resp_valid, b_resp_ready, b_busy;
    logic [5:0]  b_op, b_resp_op;
    logic [3:0]  b_start, b_abort, b_done;
    logic [1:0]  b_status;
    logic [15:0] b_cycles;

    int n_cmp;
    int n_bad;

    athos_op_responder u_dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .op_valid_i(a_op_valid), .op_i(a_op), .op_ready_o(a_op_ready),
        .eng_start_o(a_start), .eng_abort_o(a_abort), .eng_done_i(a_done),
        .resp_valid_o(a_resp_valid), .resp_ready_i(a_resp_ready),
        .resp_op_o(a_resp_op), .resp_status_o(a_status), .cycles_o(a_cycles),
        .busy_o(a_busy)
    );

    athos_op_responder #(.TIMEOUT_CYC(8), .CNT_W(16)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .op_valid_i(b_op_valid), .op_i(b_op), .op_ready_o(b_op_ready),
        .eng_start_o(b_start), .eng_abort_o(b_abort), .eng_done_i(b_done),
        .resp_valid_o(b_resp_valid), .resp_ready_i(b_resp_ready),
        .resp_op_o(b_resp_op), .resp_status_o(b_status), .cycles_o(b_cycles),
        .busy_o(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst_n = 1'b0;
        a_op_valid = 0; a_op = 0; a_done = 0; a_resp_ready = 0;
        b_op_valid = 0; b_op = 0; b_done = 0; b_resp_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        n_cmp++; if (a_op_ready !== 1'b0) begin n_bad++; $display("FAIL rst_a_ready: got %b want 0", a_op_ready); end
        n_cmp++; if ({a_busy, a_resp_valid, a_start, a_abort, a_resp_op, a_status, a_cycles} !== '0) begin n_bad++; $display("FAIL rst_a_outs: got nonzero outputs"); end
        n_cmp++; if ({b_op_ready, b_busy, b_resp_valid, b_start, b_abort} !== '0) begin n_bad++; $display("FAIL rst_b_outs: got nonzero outputs"); end
        rst_n = 1'b1; #1;
        n_cmp++; if (a_op_ready !== 1'b1) begin n_bad++; $display("FAIL rst_a_ready_after: got %b want 1", a_op_ready); end
        n_cmp++; if (b_op_ready !== 1'b1) begin n_bad++; $display("FAIL rst_b_ready_after: got %b want 1", b_op_ready); end
    endtask

    task automatic test_ntt_ok;
        @(negedge clk); a_op_valid = 1; a_op = 6'h02; #1;
        n_cmp++; if (a_op_ready !== 1'b1) begin n_bad++; $display("FAIL ntt_ready: got %b want 1", a_op_ready); end
        @(negedge clk); a_op_valid = 0; a_op = 0; #1;
        n_cmp++; if (a_start !== 4'b0010) begin n_bad++; $display("FAIL ntt_start: got %b want 0010", a_start); end
        n_cmp++; if (a_busy !== 1'b1) begin n_bad++; $display("FAIL ntt_busy: got %b want 1", a_busy); end
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk); a_done = (k == 10) ? 4'b0010 : 4'b0000; #1;
            n_cmp++; if ({a_start, a_resp_valid} !== 5'b0) begin n_bad++; $display("FAIL ntt_wait%0d: got start=%b rv=%b want 0", k, a_start, a_resp_valid); end
        end
        @(negedge clk); a_done = 0; #1;
        n_cmp++; if (a_resp_valid !== 1'b1) begin n_bad++; $display("FAIL ntt_rv: got %b want 1", a_resp_valid); end
        n_cmp++; if (a_resp_op !== 6'h02) begin n_bad++; $display("FAIL ntt_op: got %h want 02", a_resp_op); end
        n_cmp++; if (a_status !== 2'b00) begin n_bad++; $display("FAIL ntt_status: got %b want 00", a_status); end
        n_cmp++; if (a_cycles !== 16'd10) begin n_bad++; $display("FAIL ntt_cycles: got %0d want 10", a_cycles); end
        n_cmp++; if (a_op_ready !== 1'b0) begin n_bad++; $display("FAIL ntt_ready_resp: got %b want 0", a_op_ready); end
        a_resp_ready = 1;
        @(negedge clk); a_resp_ready = 0; #1;
        n_cmp++; if ({a_resp_valid, a_busy, a_op_ready} !== 3'b001) begin n_bad++; $display("FAIL ntt_idle: got rv/busy/ready=%b%b%b want 001", a_resp_valid, a_busy, a_op_ready); end
    endtask

    task automatic test_illegal_null;
        @(negedge clk); a_op_valid = 1; a_op = 6'h3F; #1;
        @(negedge clk); a_op_valid = 0; a_op = 0; #1;
        n_cmp++; if (a_start !== 4'b0000) begin n_bad++; $display("FAIL ill_start: got %b want 0000", a_start); end
        n_cmp++; if ({a_resp_valid, a_resp_op, a_status} !== {1'b1, 6'h3F, 2'b01}) begin n_bad++; $display("FAIL ill_resp: got rv=%b op=%h st=%b want 1 3f 01", a_resp_valid, a_resp_op, a_status); end
        n_cmp++; if (a_cycles !== 16'd0) begin n_bad++; $display("FAIL ill_cycles: got %0d want 0", a_cycles); end
        a_resp_ready = 1;
        @(negedge clk); a_resp_ready = 0; a_op_valid = 1; a_op = 6'h00; #1;
        n_cmp++; if (a_op_ready !== 1'b1) begin n_bad++; $display("FAIL null_ready: got %b want 1", a_op_ready); end
        @(negedge clk); a_op_valid = 0; #1;
        n_cmp++; if (a_start !== 4'b0000) begin n_bad++; $display("FAIL null_start: got %b want 0000", a_start); end
        n_cmp++; if ({a_resp_valid, a_resp_op, a_status, a_cycles} !== {1'b1, 6'h00, 2'b00, 16'd0}) begin n_bad++; $display("FAIL null_resp: got rv=%b op=%h st=%b cyc=%0d want 1 00 00 0", a_resp_valid, a_resp_op, a_status, a_cycles); end
        a_resp_ready = 1;
        @(negedge clk); a_resp_ready = 0; #1;
        n_cmp++; if (a_resp_valid !== 1'b0) begin n_bad++; $display("FAIL null_done: got rv=%b want 0", a_resp_valid); end
    endtask

    task automatic test_timeout;
        @(negedge clk); b_op_valid = 1; b_op = 6'h04;
        @(negedge clk); b_op_valid = 0; b_op = 0; #1;
        n_cmp++; if (b_start !== 4'b1000) begin n_bad++; $display("FAIL to_start: got %b want 1000", b_start); end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk); #1;
            n_cmp++; if (b_abort !== ((k == 8) ? 4'b1000 : 4'b0000)) begin n_bad++; $display("FAIL to_abort%0d: got %b", k, b_abort); end
        end
        @(negedge clk); #1;
        n_cmp++; if (b_abort !== 4'b0000) begin n_bad++; $display("FAIL to_abort_after: got %b want 0000", b_abort); end
        n_cmp++; if ({b_resp_valid, b_resp_op, b_status} !== {1'b1, 6'h04, 2'b10}) begin n_bad++; $display("FAIL to_resp: got rv=%b op=%h st=%b want 1 04 10", b_resp_valid, b_resp_op, b_status); end
        n_cmp++; if (b_cycles !== 16'd8) begin n_bad++; $display("FAIL to_cycles: got %0d want 8", b_cycles); end
        b_resp_ready = 1;
        @(negedge clk); b_resp_ready = 0;
    endtask

    task automatic test_done_at_timeout;
        @(negedge clk); b_op_valid = 1; b_op = 6'h03;
        @(negedge clk); b_op_valid = 0; b_op = 0; b_done = 4'b0100; #1;
        n_cmp++; if (b_start !== 4'b0100) begin n_bad++; $display("FAIL dt_start: got %b want 0100", b_start); end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            b_done = (k == 2) ? 4'b0001 : ((k == 8) ? 4'b0100 : 4'b0000); #1;
            n_cmp++; if ({b_abort, b_resp_valid} !== 5'b0) begin n_bad++; $display("FAIL dt_wait%0d: got abort=%b rv=%b want 0", k, b_abort, b_resp_valid); end
        end
        @(negedge clk); b_done = 0; #1;
        n_cmp++; if ({b_resp_valid, b_resp_op, b_status} !== {1'b1, 6'h03, 2'b00}) begin n_bad++; $display("FAIL dt_resp: got rv=%b op=%h st=%b want 1 03 00", b_resp_valid, b_resp_op, b_status); end
        n_cmp++; if (b_cycles !== 16'd8) begin n_bad++; $display("FAIL dt_cycles: got %0d want 8", b_cycles); end
        b_resp_ready = 1;
        @(negedge clk); b_resp_ready = 0;
    endtask

    task automatic test_back_to_back;
        @(negedge clk); a_op_valid = 1; a_op = 6'h01;
        @(negedge clk); a_op_valid = 0; a_op = 0; #1;
        n_cmp++; if (a_start !== 4'b0001) begin n_bad++; $display("FAIL bb_start: got %b want 0001", a_start); end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); a_done = (k == 3) ? 4'b0001 : 4'b0000;
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); a_done = 0; a_op_valid = 1; a_op = 6'h04; #1;
            n_cmp++; if ({a_resp_valid, a_resp_op, a_status, a_cycles} !== {1'b1, 6'h01, 2'b00, 16'd3}) begin n_bad++; $display("FAIL bb_hold%0d: got rv=%b op=%h st=%b cyc=%0d want 1 01 00 3", k, a_resp_valid, a_resp_op, a_status, a_cycles); end
            n_cmp++; if ({a_op_ready, a_start} !== 5'b0) begin n_bad++; $display("FAIL bb_block%0d: got ready=%b start=%b want 0", k, a_op_ready, a_start); end
        end
        @(negedge clk); a_op_valid = 0; a_op = 0; a_resp_ready = 1; #1;
        n_cmp++; if (a_op_ready !== 1'b0) begin n_bad++; $display("FAIL bb_hs_ready: got %b want 0", a_op_ready); end
        @(negedge clk); a_resp_ready = 0; #1;
        n_cmp++; if ({a_op_ready, a_busy} !== 2'b10) begin n_bad++; $display("FAIL bb_idle: got ready=%b busy=%b want 1 0", a_op_ready, a_busy); end
        @(negedge clk); #1;
        n_cmp++; if ({a_start, a_busy} !== 5'b0) begin n_bad++; $display("FAIL bb_no_accept: got start=%b busy=%b want 0", a_start, a_busy); end
    endtask

    task automatic test_reset_mid_op;
        @(negedge clk); a_op_valid = 1; a_op = 6'h02;
        @(negedge clk); a_op_valid = 0; a_op = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if ({a_op_ready, a_busy, a_resp_valid, a_start, a_abort, a_resp_op, a_status, a_cycles} !== '0) begin n_bad++; $display("FAIL rm_outs: got ready=%b busy=%b rv=%b want all 0", a_op_ready, a_busy, a_resp_valid); end
        rst_n = 1'b1; #1;
        n_cmp++; if ({a_op_ready, a_busy} !== 2'b10) begin n_bad++; $display("FAIL rm_idle: got ready=%b busy=%b want 1 0", a_op_ready, a_busy); end
        @(negedge clk); a_done = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); a_done = 0; #1;
            n_cmp++; if ({a_resp_valid, a_abort, a_start} !== 9'b0) begin n_bad++; $display("FAIL rm_quiet%0d: got rv=%b abort=%b start=%b want 0", k, a_resp_valid, a_abort, a_start); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_ntt_ok();
        test_illegal_null();
        test_timeout();
        test_done_at_timeout();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
